// File: rtl/gpio_pkg.sv
// Board GPIO peripheral shared definitions: register offsets, register index enum, width defaults.
// Latency: none (types and constants only).
// Backpressure: none; the peripheral bus has no stall signal.
package gpio_pkg;

   localparam int DEFAULT_NUM_SW  = 18;
   localparam int DEFAULT_NUM_KEY = 4;

   // Byte offsets within the 32-byte peripheral window
   localparam logic [4:0] GPIO_SW_IN    = 5'h00;
   localparam logic [4:0] GPIO_KEY_IN   = 5'h04;
   localparam logic [4:0] GPIO_KEY_EDGE = 5'h08;
   localparam logic [4:0] GPIO_LEDR     = 5'h0C;
   localparam logic [4:0] GPIO_IRQ_EN   = 5'h10;

   typedef enum logic [2:0] {
      REG_SW_IN,
      REG_KEY_IN,
      REG_KEY_EDGE,
      REG_LEDR,
      REG_IRQ_EN,
      REG_NONE
   } reg_idx_e;

   // Word index (address bits [4:2]) to register; unmapped words give REG_NONE
   function automatic reg_idx_e reg_index(input logic [2:0] word);
      reg_idx_e idx;
      idx = REG_NONE;
      if (word == GPIO_SW_IN[4:2])    idx = REG_SW_IN;
      if (word == GPIO_KEY_IN[4:2])   idx = REG_KEY_IN;
      if (word == GPIO_KEY_EDGE[4:2]) idx = REG_KEY_EDGE;
      if (word == GPIO_LEDR[4:2])     idx = REG_LEDR;
      if (word == GPIO_IRQ_EN[4:2])   idx = REG_IRQ_EN;
      return idx;
   endfunction

endpackage

// File: rtl/board_gpio_mmio_if.sv
// Core data-bus port into the board GPIO peripheral (address, strobes, byte enables, data).
// Latency: reads are combinational; writes commit on the clock edge where we is high.
// Backpressure: none; every access completes in the cycle it is presented.
interface board_gpio_mmio_if;
   logic [4:0]  addr;
   logic        re;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output addr, output re, output we, output be, output wdata, input rdata);
   modport slave  (input addr, input re, input we, input be, input wdata, output rdata);
endinterface

// File: rtl/gpio_debounce.sv
// Two-flop synchroniser plus optional per-bit debounce (build with GPIO_DEBOUNCE_EN) for a pin vector.
// Latency: 2 cycles pin-to-output; 2 + CYCLES cycles when debounce is built in.
// Backpressure: none; free-running sampler.
module gpio_debounce #(
   parameter int               WIDTH     = 1,
   parameter int               CYCLES    = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sync_q1;
   logic [WIDTH-1:0] sync_q2;

   // Two-flop synchroniser; reset value chosen by the instance so idle pins look idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= RESET_VAL;
         sync_q2 <= RESET_VAL;
      end else begin
         sync_q1 <= din;
         sync_q2 <= sync_q1;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int CW = $clog2(CYCLES + 1);

   logic [CW-1:0]    cnt_q [WIDTH];
   logic [WIDTH-1:0] stable_q;

   // Each bit must disagree with its stable value for CYCLES consecutive cycles before it is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_q <= RESET_VAL;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_q2[i] != stable_q[i]) begin
               if (cnt_q[i] == CW'(CYCLES - 1)) begin
                  stable_q[i] <= sync_q2[i];
                  cnt_q[i]    <= '0;
               end else begin
                  cnt_q[i] <= cnt_q[i] + 1'b1;
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

   assign dout = stable_q;
`else
   // Without debounce the synchroniser output is the stable value; CYCLES has no effect
   localparam int unused_cycles = CYCLES;
   assign dout = sync_q2;
`endif

endmodule

// File: rtl/board_gpio_mmio.sv
// Board I/O peripheral: switch/key inputs, key-press edge flags with IRQ, CPU-writable LEDs.
// Latency: reads combinational; writes visible next cycle; key_irq registered one cycle after flags.
// Backpressure: none; bus never stalls. Optional debounce via macro GPIO_DEBOUNCE_EN.
module board_gpio_mmio
   import gpio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50_000,
   parameter int NUM_SW          = DEFAULT_NUM_SW,
   parameter int NUM_KEY         = DEFAULT_NUM_KEY
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SW-1:0]  sw_raw,
   input  logic [NUM_KEY-1:0] key_raw_n,
   board_gpio_mmio_if.slave   bus,
   output logic [NUM_SW-1:0]  ledr,
   output logic               key_irq
);

   logic [NUM_SW-1:0]  sw_stable;
   logic [NUM_KEY-1:0] key_stable_n;
   logic [NUM_KEY-1:0] key_stable;
   logic [NUM_KEY-1:0] key_prev_q;
   logic [NUM_KEY-1:0] key_edge_q;
   logic [NUM_KEY-1:0] irq_en_q;
   logic [NUM_SW-1:0]  ledr_q;
   logic [NUM_KEY-1:0] key_rise;
   logic [NUM_KEY-1:0] w1c_mask;
   reg_idx_e           sel;

   // Address bits below word granularity and write-data bits above the widest register are don't-care
   wire unused_bus_bits = ^{bus.addr[1:0], bus.wdata[31:NUM_SW], bus.be[3]};

   gpio_debounce #(
      .WIDTH     (NUM_SW),
      .CYCLES    (DEBOUNCE_CYCLES),
      .RESET_VAL ({NUM_SW{1'b0}})
   ) u_sw_db (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sw_raw),
      .dout  (sw_stable)
   );

   // Keys are filtered in pin polarity (released = 1) so reset never looks like a press
   gpio_debounce #(
      .WIDTH     (NUM_KEY),
      .CYCLES    (DEBOUNCE_CYCLES),
      .RESET_VAL ({NUM_KEY{1'b1}})
   ) u_key_db (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (key_raw_n),
      .dout  (key_stable_n)
   );

   assign key_stable = ~key_stable_n;
   assign sel        = reg_index(bus.addr[4:2]);
   assign key_rise   = key_stable & ~key_prev_q;
   // KEY_EDGE and IRQ_EN live entirely in byte 0, so only be[0] qualifies their writes
   assign w1c_mask   = (bus.we && bus.be[0] && sel == REG_KEY_EDGE) ? bus.wdata[NUM_KEY-1:0] : '0;
   assign ledr       = ledr_q;

   // Register file, press-edge capture (set beats clear) and registered interrupt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_prev_q <= '0;
         key_edge_q <= '0;
         irq_en_q   <= '0;
         ledr_q     <= '0;
         key_irq    <= 1'b0;
      end else begin
         key_prev_q <= key_stable;
         key_edge_q <= (key_edge_q & ~w1c_mask) | key_rise;
         key_irq    <= |(key_edge_q & irq_en_q);
         if (bus.we && bus.be[0] && sel == REG_IRQ_EN) begin
            irq_en_q <= bus.wdata[NUM_KEY-1:0];
         end
         if (bus.we && sel == REG_LEDR) begin
            for (int i = 0; i < NUM_SW; i++) begin
               if (bus.be[i/8]) ledr_q[i] <= bus.wdata[i];
            end
         end
      end
   end

   // Combinational read mux; returns current (pre-write) contents and zero when not reading
   always_comb begin
      bus.rdata = '0;
      if (bus.re) begin
         unique case (sel)
            REG_SW_IN:    bus.rdata[NUM_SW-1:0]  = sw_stable;
            REG_KEY_IN:   bus.rdata[NUM_KEY-1:0] = key_stable;
            REG_KEY_EDGE: bus.rdata[NUM_KEY-1:0] = key_edge_q;
            REG_LEDR:     bus.rdata[NUM_SW-1:0]  = ledr_q;
            REG_IRQ_EN:   bus.rdata[NUM_KEY-1:0] = irq_en_q;
            default:      bus.rdata = '0;
         endcase
      end
   end

endmodule
